classificador_digito: RTL and testbench

- Stage directly downstream of the per-digit difference blocks (one per template digit 0..9, each producing an 11x11 array of 8-bit per-pixel differences).
- A row mux upstream presents those arrays as a row stream: digit 0 rows 0..10, then digit 1, up to digit 9.
- This block sums each digit's 121 differences into a score and tracks the minimum-score digit.
- It reports the recognised digit, its score, and whether the score is under a reject threshold.

---
 rtl/classificador_digito_pkg.sv | 26 ++
 rtl/classificador_digito_soma_linha.sv | 22 ++
 rtl/classificador_digito.sv | 113 +++++++++++
 tb/tb_classificador_digito.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/classificador_digito_pkg.sv
// Shared constants and types for the digit classifier stage that scores
// template difference arrays and picks the best-matching digit.
package classificador_digito_pkg;

  localparam int NUM_DIGITS = 10;
  localparam int NUM_ROWS   = 11;
  localparam int NUM_COLS   = 11;
  localparam int PIX_W      = 8;
  localparam int SCORE_W    = 16;
  localparam int SUM_W      = 12;
  localparam int CNT_W      = 4;

  typedef logic [SCORE_W-1:0] score_t;

  localparam score_t THRESHOLD = score_t'(6000);

  localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/classificador_digito_soma_linha.sv
// Combinational sum of one row of unsigned difference pixels; kept generic so
// other scoring stages can reuse it with their own row geometry.
module soma_linha
  import classificador_digito_pkg::*;
#(
  parameter int N_COLS = NUM_COLS,
  parameter int P_W    = PIX_W,
  parameter int S_W    = SUM_W
) (
  input  logic [N_COLS*P_W-1:0] row,
  output logic [S_W-1:0]        sum
);

  // Written as a chain; synthesis rebalances it into a tree.
  always_comb begin
    sum = '0;
    for (int c = 0; c < N_COLS; c++) begin
      sum = sum + S_W'(row[c*P_W +: P_W]);
    end
  end

endmodule

// File: rtl/classificador_digito.sv
// Accumulates each template digit's 121 differences into a score and reports
// the lowest-scoring digit, its score and whether it passes the reject threshold.
module classificador_digito
  import classificador_digito_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_COLS*PIX_W-1:0] diff_row,
  input  logic                      row_valid,
  output logic                      row_ready,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                digit_out,
  output logic [SCORE_W-1:0]        min_score,
  output logic                      match_ok
);

  state_t           state;
  score_t           acc;
  score_t           best_score;
  logic [CNT_W-1:0] row_cnt;
  logic [CNT_W-1:0] dig_cnt;
  logic [CNT_W-1:0] best_idx;
  logic             best_valid;

  logic [SUM_W-1:0] row_sum;
  score_t           cand;
  score_t           next_score;
  logic [CNT_W-1:0] next_idx;
  logic             accept;
  logic             take;

  soma_linha #(
    .N_COLS(NUM_COLS),
    .P_W   (PIX_W),
    .S_W   (SUM_W)
  ) u_soma_linha (
    .row(diff_row),
    .sum(row_sum)
  );

  // Strict less-than keeps the earlier (lower) digit on ties.
  assign accept     = (state == ACCUM) && row_valid && row_ready;
  assign cand       = acc + score_t'(row_sum);
  assign take       = !best_valid || (cand < best_score);
  assign next_score = take ? cand : best_score;
  assign next_idx   = take ? dig_cnt : best_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      best_score <= '0;
      row_cnt    <= '0;
      dig_cnt    <= '0;
      best_idx   <= '0;
      best_valid <= 1'b0;
      row_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      digit_out  <= '0;
      min_score  <= '0;
      match_ok   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= '0;
            row_cnt    <= '0;
            dig_cnt    <= '0;
            best_valid <= 1'b0;
            busy       <= 1'b1;
            row_ready  <= 1'b1;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (row_cnt != LAST_ROW) begin
              acc     <= cand;
              row_cnt <= row_cnt + 1'b1;
            end else begin
              best_score <= next_score;
              best_idx   <= next_idx;
              best_valid <= 1'b1;
              acc        <= '0;
              row_cnt    <= '0;
              // Results are loaded here so they are valid alongside done.
              if (dig_cnt == LAST_DIGIT) begin
                row_ready <= 1'b0;
                done      <= 1'b1;
                digit_out <= next_idx;
                min_score <= next_score;
                match_ok  <= (next_score <= THRESHOLD);
                state     <= DONE;
              end else begin
                dig_cnt <= dig_cnt + 1'b1;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_classificador_digito.sv
// Randomized scoreboard bench: the driver streams frames and queues the
// expected result, an independent monitor checks every done pulse.
module tb_classificador_digito;
  import classificador_digito_pkg::*;

  localparam int FRAME_ROWS = NUM_DIGITS * NUM_ROWS;
  localparam int ROW_W      = NUM_COLS * PIX_W;

  typedef struct {
    int digit;
    int score;
    int ok;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ROW_W-1:0]  diff_row;
  logic              row_valid;
  logic              row_ready;
  logic              busy;
  logic              done;
  logic [3:0]        digit_out;
  logic [SCORE_W-1:0] min_score;
  logic              match_ok;

  classificador_digito dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .diff_row (diff_row),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .busy     (busy),
    .done     (done),
    .digit_out(digit_out),
    .min_score(min_score),
    .match_ok (match_ok)
  );

  logic [ROW_W-1:0] frame_rows [FRAME_ROWS];
  exp_t             sb [$];
  int               vectors;
  int               miscompares;
  int               cycle;
  int               last_accept_cycle;
  int               done_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: score = plain sum of every pixel of a digit; lowest score wins,
  // earliest digit wins ties.
  function automatic void pushExpected();
    exp_t e;
    int best = -1;
    int best_s = 0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      int s = 0;
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < NUM_COLS; c++)
          s += int'(frame_rows[d*NUM_ROWS + r][c*PIX_W +: PIX_W]);
      if (best < 0 || s < best_s) begin
        best   = d;
        best_s = s;
      end
    end
    e.digit = best;
    e.score = best_s;
    e.ok    = (best_s <= 6000) ? 1 : 0;
    sb.push_back(e);
  endfunction

  function automatic void fillDigit(input int d, input int v);
    logic [PIX_W-1:0] b;
    b = PIX_W'(v);
    for (int r = 0; r < NUM_ROWS; r++)
      frame_rows[d*NUM_ROWS + r] = {NUM_COLS{b}};
  endfunction

  function automatic void fillRandom();
    for (int d = 0; d < NUM_DIGITS; d++) begin
      int cap = $urandom_range(0, 255);
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < NUM_COLS; c++)
          frame_rows[d*NUM_ROWS + r][c*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, cap));
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      done_count++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: done=1 with no frame outstanding");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("digit_out", int'(digit_out), e.digit);
        checkOutput("min_score", int'(min_score), e.score);
        checkOutput("match_ok", int'(match_ok), e.ok);
        checkOutput("done_latency", cycle - last_accept_cycle, 1);
      end
    end
  end

  task automatic sendRow(input logic [ROW_W-1:0] row, input bit gaps, input bit with_start);
    bit accepted;
    int waits;
    for (int g = 0; g < 8 && gaps && ($urandom_range(0, 1) == 1); g++) begin
      row_valid = 1'b0;
      @(posedge clk); #1;
    end
    diff_row  = row;
    row_valid = 1'b1;
    start     = with_start;
    accepted  = 1'b0;
    waits     = 0;
    while (!accepted) begin
      @(negedge clk);
      if (row_ready) begin
        accepted          = 1'b1;
        last_accept_cycle = cycle;
      end
      @(posedge clk); #1;
      waits++;
      if (!accepted && waits > 50) begin
        $display("[TB] FAIL row_accept_timeout: row_ready stuck at 0, expected 1");
        $fatal(1, "[TB] row handshake never completed");
      end
    end
    start     = 1'b0;
    row_valid = 1'b0;
  endtask

  // Drives one frame; start_at pulses start mid-frame, abort_at resets mid-frame.
  task automatic applyStimulus(input bit gaps, input int start_at, input int abort_at);
    int done_before;
    if (abort_at < 0) pushExpected();
    done_before = done_count;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_start", int'(busy), 1);
    @(posedge clk); #1;
    for (int i = 0; i < FRAME_ROWS; i++) begin
      if (i == abort_at) begin
        row_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_row_ready", int'(row_ready), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_digit_out", int'(digit_out), 0);
        checkOutput("abort_min_score", int'(min_score), 0);
        checkOutput("abort_match_ok", int'(match_ok), 0);
        return;
      end
      sendRow(frame_rows[i], gaps, (i == start_at));
    end
    for (int k = 0; k < 10 && done_count == done_before; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    checkOutput("done_pulses", done_count - done_before, 1);
    if (done_count == done_before) sb.delete();
    #1;
    // Rows offered while idle must not be taken.
    for (int k = 0; k < 3; k++) begin
      diff_row  = ROW_W'({$urandom(), $urandom(), $urandom()});
      row_valid = 1'b1;
      @(negedge clk);
      checkOutput("idle_row_ready", int'(row_ready), 0);
      checkOutput("idle_busy", int'(busy), 0);
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors           = 0;
    miscompares       = 0;
    cycle             = 0;
    last_accept_cycle = 0;
    done_count        = 0;
    reset             = 1'b1;
    start             = 1'b0;
    row_valid         = 1'b0;
    diff_row          = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_row_ready", int'(row_ready), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_digit_out", int'(digit_out), 0);
    checkOutput("reset_min_score", int'(min_score), 0);
    checkOutput("reset_match_ok", int'(match_ok), 0);
    #1 reset = 1'b0;

    for (int d = 0; d < NUM_DIGITS; d++) fillDigit(d, (d == 3) ? 0 : 5);
    applyStimulus(1'b0, -1, -1);

    for (int d = 0; d < NUM_DIGITS; d++) fillDigit(d, 7);
    applyStimulus(1'b0, -1, -1);

    for (int d = 0; d < NUM_DIGITS; d++) fillDigit(d, 255);
    applyStimulus(1'b0, -1, -1);

    for (int d = 0; d < NUM_DIGITS; d++) fillDigit(d, (d == 9) ? 40 : 255);
    applyStimulus(1'b0, -1, -1);

    for (int d = 0; d < NUM_DIGITS; d++) fillDigit(d, (d == 3) ? 0 : 5);
    applyStimulus(1'b1, -1, -1);

    fillRandom();
    applyStimulus(1'b0, 37, -1);

    fillRandom();
    applyStimulus(1'b0, -1, 50);
    fillRandom();
    applyStimulus(1'b0, -1, -1);

    for (int n = 0; n < 6; n++) begin
      fillRandom();
      applyStimulus(1'($urandom_range(0, 1)), -1, -1);
    end

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
